risc_controller: RTL and testbench



---
 rtl/risc_controller.sv | 130 +++++++++++++
 tb/tb_risc_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/risc_controller.sv
// risc_controller: eight-phase fetch/decode/execute sequencer for the 8-bit
// accumulator CPU. A free-running phase counter is decoded together with the
// current opcode and the ALU zero flag into memory, IR, PC and accumulator
// strobes. HLT freezes the sequencer in OP_ADDR until rst_n is asserted.
module risc_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  localparam logic [2:0] PH_INST_ADDR  = 3'd0;
  localparam logic [2:0] PH_INST_FETCH = 3'd1;
  localparam logic [2:0] PH_INST_LOAD  = 3'd2;
  localparam logic [2:0] PH_IDLE       = 3'd3;
  localparam logic [2:0] PH_OP_ADDR    = 3'd4;
  localparam logic [2:0] PH_OP_FETCH   = 3'd5;
  localparam logic [2:0] PH_ALU_OP     = 3'd6;
  localparam logic [2:0] PH_STORE      = 3'd7;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  logic [2:0] r_phase;
  logic       r_halted;
  logic       w_aluop;
  logic       w_is_hlt;
  logic       w_hlt_decode;
  logic       w_set_halt;
  logic       w_hold;

  // Opcodes that read an operand and write the accumulator.
  assign w_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);
  assign w_is_hlt = (opcode == OP_HLT);
  // HLT is decoded while sitting in OP_ADDR.
  assign w_hlt_decode = (r_phase == PH_OP_ADDR) && w_is_hlt;
  // Latch halt on the edge entering OP_ADDR; the OP_ADDR term also catches
  // an HLT that only becomes visible once already in OP_ADDR.
  assign w_set_halt = ((r_phase == PH_IDLE) && w_is_hlt) || w_hlt_decode;
  // Once halted (or halting) the phase is parked at OP_ADDR.
  assign w_hold = r_halted || w_hlt_decode;

  // Phase counter and sticky halted flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase  <= PH_INST_ADDR;
      r_halted <= 1'b0;
    end else begin
      if (w_hold) begin
        r_phase <= PH_OP_ADDR;
      end else begin
        r_phase <= r_phase + 3'd1;
      end
      r_halted <= r_halted | w_set_halt;
    end
  end

  // Strobe decode from the phase, opcode and zero flag; silent while halted.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = r_halted | w_hlt_decode;
    if (r_halted) begin
      sel = 1'b0;
    end else begin
      case (r_phase)
        PH_INST_ADDR: begin
          sel = 1'b1;
        end
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          inc_pc = !w_is_hlt;
        end
        PH_OP_FETCH: begin
          rd = w_aluop;
        end
        PH_ALU_OP: begin
          rd     = w_aluop;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        PH_STORE: begin
          rd     = w_aluop;
          ld_ac  = w_aluop;
          ld_pc  = (opcode == OP_JMP);
          wr     = (opcode == OP_STO);
          data_e = (opcode == OP_STO);
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

  assign phase = r_phase;

endmodule

// File: tb/tb_risc_controller.sv
// tb_risc_controller: directed bench for risc_controller. A behavioural model
// (phase integer, halted bit, spec-level output rules) is compared against the
// DUT every cycle; per-instruction strobe masks are checked against
// hand-computed literals.
module tb_risc_controller;

  logic       clk;
  logic       rst_n;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  int m_phase  = 0;
  bit m_halted = 1'b0;

  logic [7:0] mk_sel, mk_rd, mk_ld_ir, mk_inc_pc, mk_ld_pc, mk_ld_ac, mk_wr, mk_data_e;

  risc_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt), .phase(phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt}.
  function automatic logic [8:0] model_out(input int p, input int op, input bit z, input bit halted);
    bit aluop;
    bit e_sel, e_rd, e_ir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt;
    aluop  = (op >= 2) && (op <= 5);
    e_halt = halted || (p == 4 && op == 0);
    if (halted) return 9'b0_0000_0001;
    e_sel  = (p <= 3);
    e_rd   = (p >= 1 && p <= 3) || (p >= 5 && aluop);
    e_ir   = (p == 2) || (p == 3);
    e_inc  = (p == 4 && op != 0) || (p == 6 && op == 1 && z);
    e_ldpc = (p == 6 || p == 7) && op == 7;
    e_ldac = (p == 7) && aluop;
    e_wr   = (p == 7) && op == 6;
    e_de   = (p == 6 || p == 7) && op == 6;
    return {e_sel, e_rd, e_ir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt};
  endfunction

  // Model state: advance one phase per clock; HLT entering OP_ADDR halts.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase  = 0;
      m_halted = 1'b0;
    end else if (m_halted || (m_phase == 4 && opcode == 3'd0)) begin
      m_phase  = 4;
      m_halted = 1'b1;
    end else if (m_phase == 3 && opcode == 3'd0) begin
      m_phase  = 4;
      m_halted = 1'b1;
    end else begin
      m_phase = (m_phase + 1) % 8;
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [11:0] got, exp;
      got = {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
      exp = {3'(m_phase), model_out(m_phase, int'(opcode), zero, m_halted)};
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL cycle_cmp t=%0t got=%b exp=%b", $time, got, exp);
    end
  end

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  // Run one instruction starting just after a phase-0 negedge; record masks.
  task automatic run_instr(input logic [2:0] op, input logic z);
    int p;
    opcode = op;
    zero   = z;
    {mk_sel, mk_rd, mk_ld_ir, mk_inc_pc, mk_ld_pc, mk_ld_ac, mk_wr, mk_data_e} = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      p = (i + 1) % 8;
      mk_sel[p]    = sel;
      mk_rd[p]     = rd;
      mk_ld_ir[p]  = ld_ir;
      mk_inc_pc[p] = inc_pc;
      mk_ld_pc[p]  = ld_pc;
      mk_ld_ac[p]  = ld_ac;
      mk_wr[p]     = wr;
      mk_data_e[p] = data_e;
    end
    #2;
  endtask

  initial begin
    int guard;
    rst_n  = 1'b1;
    opcode = 3'd2;
    zero   = 1'b0;

    // Model pinning with hand-computed vectors.
    chk("model_skz_p6",  {3'd0, model_out(6, 1, 1'b1, 1'b0)}, 12'b000_000100000);
    chk("model_sto_p7",  {3'd0, model_out(7, 6, 1'b0, 1'b0)}, 12'b000_000000110);
    chk("model_hlt_p4",  {3'd0, model_out(4, 0, 1'b0, 1'b0)}, 12'b000_000000001);
    chk("model_halted",  {3'd0, model_out(2, 2, 1'b0, 1'b1)}, 12'b000_000000001);

    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt},
        12'b000_100000000);
    #2 rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("phase_seq", {9'd0, phase}, 12'(i % 8));
    end
    #2;

    // ADD
    run_instr(3'd2, 1'b0);
    chk("add_rd",     {4'd0, mk_rd},     12'h0EE);
    chk("add_ld_ir",  {4'd0, mk_ld_ir},  12'h00C);
    chk("add_inc_pc", {4'd0, mk_inc_pc}, 12'h010);
    chk("add_ld_ac",  {4'd0, mk_ld_ac},  12'h080);
    chk("add_quiet",  {4'd0, mk_wr | mk_ld_pc | mk_data_e}, 12'h000);
    chk("add_sel",    {4'd0, mk_sel},    12'h00F);

    // SKZ with and without zero
    run_instr(3'd1, 1'b1);
    chk("skz1_inc_pc", {4'd0, mk_inc_pc}, 12'h050);
    chk("skz1_ld_ac",  {4'd0, mk_ld_ac},  12'h000);
    run_instr(3'd1, 1'b0);
    chk("skz0_inc_pc", {4'd0, mk_inc_pc}, 12'h010);
    chk("skz0_ld_ac",  {4'd0, mk_ld_ac},  12'h000);

    // STO and JMP
    run_instr(3'd6, 1'b0);
    chk("sto_data_e", {4'd0, mk_data_e}, 12'h0C0);
    chk("sto_wr",     {4'd0, mk_wr},     12'h080);
    chk("sto_rd",     {4'd0, mk_rd},     12'h00E);
    run_instr(3'd7, 1'b1);
    chk("jmp_ld_pc",  {4'd0, mk_ld_pc},  12'h0C0);
    chk("jmp_wr",     {4'd0, mk_wr},     12'h000);

    // LDA exercises another ALUOP opcode through the model.
    run_instr(3'd5, 1'b0);
    chk("lda_ld_ac",  {4'd0, mk_ld_ac},  12'h080);

    // Reset in phase 5 of an ADD.
    opcode = 3'd2;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (phase != 3'd5 && guard < 16);
    chk("find_phase5", {9'd0, phase}, 12'd5);
    #2 rst_n = 1'b0;
    #1 chk("mid_reset", {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt},
           12'b000_100000000);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_instr(3'd2, 1'b0);
    chk("post_reset_ld_ac", {4'd0, mk_ld_ac}, 12'h080);

    // HLT: halt in phase 4, then frozen even after opcode changes.
    opcode = 3'd0;
    for (int i = 1; i <= 4; i++) @(negedge clk);
    chk("hlt_p4", {phase, inc_pc, 7'd0, halt}, 12'b100_0_0000000_1);
    #2 opcode = 3'd2;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      chk("halted_hold", {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt},
          12'b100_000000001);
    end
    #2 rst_n = 1'b0;
    #1 chk("halt_reset", {phase, sel, 7'd0, halt}, 12'b000_1_0000000_0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_instr(3'd2, 1'b0);
    chk("restart_inc_pc", {4'd0, mk_inc_pc}, 12'h010);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
